fsm_add_subt_hs_ctrl: RTL and testbench
=======================================

Name: fsm_add_subt_hs_ctrl

Overview:
Parametrised next-generation control FSM for the FP add/subtract datapath. It drives the same load enables and mux selects as the current add/subt controller, with these additions:
- Internal normalisation-pass tracking, replacing the external norm-iteration input.
- start/ready/ack handshake with back-to-back issue.
- Synchronous abort.
- Optional rounding path.
- Per-operation latency counter.

It sits between the FPU top-level sequencer and the Oper_Start_In / Exp_operation / Barrel_Shifter / Add_Subt_Sgf / LZA / Final_Result stages.

Parameters:
ROUND_EN, 1, 1 = round-check/round-add path present; 0 = NORM on pass 1 goes straight to LOAD_RESULT
ZERO_BYPASS, 1, 1 = zero_flag_i in ZERO_CHK jumps to DONE; 0 = flag ignored
CNT_W, 6, width of the saturating latency counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start_i  in  1  operation request, sampled in IDLE and in DONE
ack_i  in  1  consumer accepts the result, sampled in DONE
abort_i  in  1  synchronous abort of the operation in flight
zero_flag_i  in  1  zero-operand condition from Oper_Start_In
add_overflow_i  in  1  significand adder overflow
round_i  in  1  round-up decision from Deco_round
load_1_o .. load_7_o  out  1 each  stage register enables
A_S_op_o  out  1  exponent op select: 1 = subtract, 0 = add
left_right_o  out  1  shift direction: 1 = left, 0 = right
bit_shift_o  out  1  shift fill bit
ctrl_a_o, ctrl_c_o, ctrl_d_o  out  1 each  mux selects
ctrl_b_o, ctrl_e_o  out  2 each  mux selects
rst_int  out  1  datapath internal reset
busy_o  out  1  operation in flight
ready_o  out  1  result valid
lat_cnt_o  out  CNT_W  cycles spent in the last or current operation

Behaviour:
State machine
- 4-bit state register; the only sequential elements are the state, the pass flag pass_q and lat_cnt.
- Outputs are combinational from state and inputs.
- Per-cycle defaults: all loads 0, A_S_op_o=1, every other output 0.
- Reset (rst=0): state=IDLE, pass_q=0, lat_cnt=0. Outputs then take their IDLE values: rst_int=1, everything else at default.

States (output assignments, then transition):
- IDLE: rst_int=1. start_i -> LOAD_OPER, clear lat_cnt and pass_q.
- LOAD_OPER: load_1=1 -> ZERO_CHK.
- ZERO_CHK: if zero_flag_i and ZERO_BYPASS -> DONE; else load_2=1 -> LOAD_EXP.
- LOAD_EXP: load_3=1 -> NORM.
- NORM: load_4=1. pass_q=0 -> ADD_SUBT. pass_q=1 -> ROUND_CHK if ROUND_EN=1, else LOAD_RESULT.
- ADD_SUBT: load_5=load_6=1, ctrl_a=1, ctrl_c=1 -> OVF_CHK.
- OVF_CHK: load_2=1, set pass_q=1.
  - Overflow set: A_S_op=0, ctrl_b=10, ctrl_e=10, left_right=0, bit_shift=1.
  - Overflow clear: ctrl_b=01, ctrl_e=01, left_right=1.
  - Either case -> LOAD_EXP.
- ROUND_CHK: load_5=1. round_i: ctrl_d=1 -> ADD_SUBT_R; else -> LOAD_RESULT.
- ADD_SUBT_R: overflow set: same selects as OVF_CHK overflow -> LOAD_EXP_R. Overflow clear: ctrl_e=11 -> NORM_R.
- LOAD_EXP_R: load_3=1 -> NORM_R.
- NORM_R: load_4=1 -> LOAD_RESULT.
- LOAD_RESULT: load_7=1 -> DONE.
- DONE: ready_o=1. Transitions:
  - ack_i with start_i -> LOAD_OPER (back-to-back issue; lat_cnt and pass_q cleared).
  - ack_i alone -> IDLE.
  - No ack_i: hold DONE; start_i is ignored.

Status outputs and counter
- busy_o=1 in every state except IDLE and DONE.
- lat_cnt increments on every busy cycle. It saturates at 2^CNT_W-1 and holds its value in DONE and IDLE until the next start.

Abort and reset
- abort_i while busy: next state IDLE, pass_q cleared, no load_7 issued, lat_cnt frozen.
- abort_i is ignored in IDLE and DONE.
- abort_i has priority over all other transitions.
- Reset deassertion mid-operation: the FSM restarts from IDLE with no residual loads.

Decomposition:
- Shared package fpu_add_subt_pkg holds:
  - state localparams IDLE=0 .. DONE=12, in the order listed above;
  - the ctrl_b / ctrl_e encodings (00 default, 01 left-normalise, 10 overflow, 11 round-no-overflow).
- One sub-module, fsm_add_subt_lat_cnt: saturating counter with clear, enable and CNT_W parameter.

Test Plan:
- start_i pulse, zero=0, ovf=0, round=0 -> busy_o from cycle 1, ready_o at cycle 11, lat_cnt_o=10, load_7 exactly once, at cycle 10.
- Same stimulus with round_i=1, ovf=0 in ADD_SUBT_R -> ctrl_e=11 there, ready_o at cycle 13, lat_cnt_o=12. With ovf=1 there -> LOAD_EXP_R visited, ready_o at cycle 14, lat_cnt_o=13.
- zero_flag_i=1 -> ready_o at cycle 3, lat_cnt_o=2, no load_2..7. With ZERO_BYPASS=0 -> full path, 10 cycles.
- ROUND_EN=0, round_i=1 -> ctrl_d never asserted, ready_o at cycle 10, lat_cnt_o=9.
- In DONE, hold ack_i=0 for 5 cycles with start_i=1 -> ready_o held, no new load_1. Then ack_i=start_i=1 -> load_1 on the next cycle, lat_cnt reset to 0.
- abort_i at cycle 6 (OVF_CHK) -> IDLE at cycle 7, rst_int=1, ready_o never asserted. Async rst=0 at cycle 4 -> all loads 0 immediately, state IDLE.

Source files
------------

// File: rtl/fpu_add_subt_pkg.sv
// ----------------------------------------------------------------------------
// fpu_add_subt_pkg
// Shared definitions for the FP add/subtract control path.
//   - state_t        : controller state encoding, IDLE=0 .. DONE=12
//   - SEL_*          : encodings shared by the ctrl_b / ctrl_e mux selects
//   - state_is_busy  : 1 for every state that belongs to an operation in flight
// ----------------------------------------------------------------------------
package fpu_add_subt_pkg;

    // Controller states, numbered in the order the operation walks through them
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        LOAD_OPER   = 4'd1,
        ZERO_CHK    = 4'd2,
        LOAD_EXP    = 4'd3,
        NORM        = 4'd4,
        ADD_SUBT    = 4'd5,
        OVF_CHK     = 4'd6,
        ROUND_CHK   = 4'd7,
        ADD_SUBT_R  = 4'd8,
        LOAD_EXP_R  = 4'd9,
        NORM_R      = 4'd10,
        LOAD_RESULT = 4'd11,
        DONE        = 4'd12
    } state_t;

    // ctrl_b / ctrl_e select encodings
    localparam logic [1:0] SEL_DEFAULT    = 2'b00;
    localparam logic [1:0] SEL_LEFT_NORM  = 2'b01;
    localparam logic [1:0] SEL_OVERFLOW   = 2'b10;
    localparam logic [1:0] SEL_ROUND_NOVF = 2'b11;

    // IDLE and DONE are the only states outside an operation
    function automatic logic state_is_busy(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/fsm_add_subt_lat_cnt.sv
// ----------------------------------------------------------------------------
// fsm_add_subt_lat_cnt
// Saturating up-counter used to measure per-operation latency.
// Ports:
//   clk  in          system clock
//   rst  in          asynchronous active-low reset
//   clr  in          synchronous clear (takes priority over en)
//   en   in          count enable
//   cnt  out [CNT_W] current count, sticks at 2^CNT_W-1
// ----------------------------------------------------------------------------
module fsm_add_subt_lat_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over enable so a new operation always starts from zero;
    // at full scale the counter sticks rather than wrapping to a small value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fsm_add_subt_hs_ctrl.sv
// ----------------------------------------------------------------------------
// fsm_add_subt_hs_ctrl
// Control FSM for the FP add/subtract datapath with start/ready/ack handshake,
// internal normalisation-pass tracking, synchronous abort, optional rounding
// path and a per-operation latency counter.
// Parameters:
//   ROUND_EN    1 = round-check / round-add path present
//   ZERO_BYPASS 1 = zero_flag_i in ZERO_CHK finishes the operation early
//   CNT_W       width of the saturating latency counter
// Ports:
//   clk, rst (async active-low)
//   start_i, ack_i, abort_i         handshake / abort from the sequencer
//   zero_flag_i, add_overflow_i,
//   round_i                         datapath status
//   load_1_o .. load_7_o            stage register enables
//   A_S_op_o, left_right_o,
//   bit_shift_o                     exponent op / shifter controls
//   ctrl_a_o .. ctrl_e_o            mux selects
//   rst_int                         datapath internal reset (high in IDLE)
//   busy_o, ready_o                 status
//   lat_cnt_o                       cycles spent in the last/current operation
// ----------------------------------------------------------------------------
module fsm_add_subt_hs_ctrl
    import fpu_add_subt_pkg::*;
#(
    parameter bit ROUND_EN    = 1'b1,
    parameter bit ZERO_BYPASS = 1'b1,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             ack_i,
    input  logic             abort_i,
    input  logic             zero_flag_i,
    input  logic             add_overflow_i,
    input  logic             round_i,
    output logic             load_1_o,
    output logic             load_2_o,
    output logic             load_3_o,
    output logic             load_4_o,
    output logic             load_5_o,
    output logic             load_6_o,
    output logic             load_7_o,
    output logic             A_S_op_o,
    output logic             left_right_o,
    output logic             bit_shift_o,
    output logic             ctrl_a_o,
    output logic [1:0]       ctrl_b_o,
    output logic             ctrl_c_o,
    output logic             ctrl_d_o,
    output logic [1:0]       ctrl_e_o,
    output logic             rst_int,
    output logic             busy_o,
    output logic             ready_o,
    output logic [CNT_W-1:0] lat_cnt_o
);

    state_t state_q;
    state_t state_d;
    logic   pass_q;
    logic   pass_d;
    logic   cnt_clr;
    logic   busy;

    assign busy   = state_is_busy(state_q);
    assign busy_o = busy;

    // State and normalisation-pass flag. pass_q records that the first
    // add/overflow-check pass is done, so the second visit to NORM heads
    // for rounding / result instead of another add.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    // Next state and outputs. An abort during an operation drops straight to
    // IDLE and keeps every output at its default for that cycle, so no stage
    // register (in particular the result register) is written on the way out.
    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        cnt_clr      = 1'b0;
        load_1_o     = 1'b0;
        load_2_o     = 1'b0;
        load_3_o     = 1'b0;
        load_4_o     = 1'b0;
        load_5_o     = 1'b0;
        load_6_o     = 1'b0;
        load_7_o     = 1'b0;
        A_S_op_o     = 1'b1;
        left_right_o = 1'b0;
        bit_shift_o  = 1'b0;
        ctrl_a_o     = 1'b0;
        ctrl_b_o     = SEL_DEFAULT;
        ctrl_c_o     = 1'b0;
        ctrl_d_o     = 1'b0;
        ctrl_e_o     = SEL_DEFAULT;
        rst_int      = 1'b0;
        ready_o      = 1'b0;

        if (busy && abort_i) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rst_int = 1'b1;
                    if (start_i) begin
                        state_d = LOAD_OPER;
                        pass_d  = 1'b0;
                        cnt_clr = 1'b1;
                    end
                end

                LOAD_OPER: begin
                    load_1_o = 1'b1;
                    state_d  = ZERO_CHK;
                end

                ZERO_CHK: begin
                    if (zero_flag_i && ZERO_BYPASS) begin
                        state_d = DONE;
                    end else begin
                        load_2_o = 1'b1;
                        state_d  = LOAD_EXP;
                    end
                end

                LOAD_EXP: begin
                    load_3_o = 1'b1;
                    state_d  = NORM;
                end

                NORM: begin
                    load_4_o = 1'b1;
                    if (!pass_q) begin
                        state_d = ADD_SUBT;
                    end else if (ROUND_EN) begin
                        state_d = ROUND_CHK;
                    end else begin
                        state_d = LOAD_RESULT;
                    end
                end

                ADD_SUBT: begin
                    load_5_o = 1'b1;
                    load_6_o = 1'b1;
                    ctrl_a_o = 1'b1;
                    ctrl_c_o = 1'b1;
                    state_d  = OVF_CHK;
                end

                // Overflow: add one to the exponent and shift right with a
                // leading one; otherwise set up the left-normalise shift.
                OVF_CHK: begin
                    load_2_o = 1'b1;
                    pass_d   = 1'b1;
                    if (add_overflow_i) begin
                        A_S_op_o     = 1'b0;
                        ctrl_b_o     = SEL_OVERFLOW;
                        ctrl_e_o     = SEL_OVERFLOW;
                        left_right_o = 1'b0;
                        bit_shift_o  = 1'b1;
                    end else begin
                        ctrl_b_o     = SEL_LEFT_NORM;
                        ctrl_e_o     = SEL_LEFT_NORM;
                        left_right_o = 1'b1;
                    end
                    state_d = LOAD_EXP;
                end

                ROUND_CHK: begin
                    load_5_o = 1'b1;
                    if (round_i) begin
                        ctrl_d_o = 1'b1;
                        state_d  = ADD_SUBT_R;
                    end else begin
                        state_d  = LOAD_RESULT;
                    end
                end

                // The round-up add can itself overflow, which needs one more
                // exponent adjust before the final normalise.
                ADD_SUBT_R: begin
                    if (add_overflow_i) begin
                        A_S_op_o     = 1'b0;
                        ctrl_b_o     = SEL_OVERFLOW;
                        ctrl_e_o     = SEL_OVERFLOW;
                        left_right_o = 1'b0;
                        bit_shift_o  = 1'b1;
                        state_d      = LOAD_EXP_R;
                    end else begin
                        ctrl_e_o     = SEL_ROUND_NOVF;
                        state_d      = NORM_R;
                    end
                end

                LOAD_EXP_R: begin
                    load_3_o = 1'b1;
                    state_d  = NORM_R;
                end

                NORM_R: begin
                    load_4_o = 1'b1;
                    state_d  = LOAD_RESULT;
                end

                LOAD_RESULT: begin
                    load_7_o = 1'b1;
                    state_d  = DONE;
                end

                // The result stays presented until acknowledged; a start
                // without ack is not accepted so the result cannot be lost.
                DONE: begin
                    ready_o = 1'b1;
                    if (ack_i) begin
                        if (start_i) begin
                            state_d = LOAD_OPER;
                            pass_d  = 1'b0;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    // Counts busy cycles; the abort cycle itself is not counted so the value
    // left behind is the work done before the abort.
    fsm_add_subt_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (busy && !abort_i),
        .cnt (lat_cnt_o)
    );

endmodule

// File: tb/tb_fsm_add_subt_hs_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fsm_add_subt_hs_ctrl
// Three controller instances share one stimulus stream:
//   dut 0 : ROUND_EN=1, ZERO_BYPASS=1, CNT_W=6
//   dut 1 : ROUND_EN=0, ZERO_BYPASS=0, CNT_W=6
//   dut 2 : ROUND_EN=1, ZERO_BYPASS=1, CNT_W=3 (counter saturates at 7)
// The reference model predicts, from the datapath flags, how many busy
// cycles an operation takes and how many pulses each load enable gives.
// ----------------------------------------------------------------------------
module tb_fsm_add_subt_hs_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic ack_i;
    logic abort_i;
    logic zero_flag_i;
    logic add_overflow_i;
    logic round_i;

    logic [7:1] ld [3];
    logic [2:0] as_op, lr, bs, ca, cc, cd, rsti, busy, rdy;
    logic [1:0] cb [3];
    logic [1:0] ce [3];
    logic [5:0] lat0, lat1;
    logic [2:0] lat2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fsm_add_subt_hs_ctrl #(.ROUND_EN(1'b1), .ZERO_BYPASS(1'b1), .CNT_W(6)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .abort_i(abort_i),
        .zero_flag_i(zero_flag_i), .add_overflow_i(add_overflow_i), .round_i(round_i),
        .load_1_o(ld[0][1]), .load_2_o(ld[0][2]), .load_3_o(ld[0][3]), .load_4_o(ld[0][4]),
        .load_5_o(ld[0][5]), .load_6_o(ld[0][6]), .load_7_o(ld[0][7]),
        .A_S_op_o(as_op[0]), .left_right_o(lr[0]), .bit_shift_o(bs[0]),
        .ctrl_a_o(ca[0]), .ctrl_b_o(cb[0]), .ctrl_c_o(cc[0]), .ctrl_d_o(cd[0]), .ctrl_e_o(ce[0]),
        .rst_int(rsti[0]), .busy_o(busy[0]), .ready_o(rdy[0]), .lat_cnt_o(lat0));

    fsm_add_subt_hs_ctrl #(.ROUND_EN(1'b0), .ZERO_BYPASS(1'b0), .CNT_W(6)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .abort_i(abort_i),
        .zero_flag_i(zero_flag_i), .add_overflow_i(add_overflow_i), .round_i(round_i),
        .load_1_o(ld[1][1]), .load_2_o(ld[1][2]), .load_3_o(ld[1][3]), .load_4_o(ld[1][4]),
        .load_5_o(ld[1][5]), .load_6_o(ld[1][6]), .load_7_o(ld[1][7]),
        .A_S_op_o(as_op[1]), .left_right_o(lr[1]), .bit_shift_o(bs[1]),
        .ctrl_a_o(ca[1]), .ctrl_b_o(cb[1]), .ctrl_c_o(cc[1]), .ctrl_d_o(cd[1]), .ctrl_e_o(ce[1]),
        .rst_int(rsti[1]), .busy_o(busy[1]), .ready_o(rdy[1]), .lat_cnt_o(lat1));

    fsm_add_subt_hs_ctrl #(.ROUND_EN(1'b1), .ZERO_BYPASS(1'b1), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .abort_i(abort_i),
        .zero_flag_i(zero_flag_i), .add_overflow_i(add_overflow_i), .round_i(round_i),
        .load_1_o(ld[2][1]), .load_2_o(ld[2][2]), .load_3_o(ld[2][3]), .load_4_o(ld[2][4]),
        .load_5_o(ld[2][5]), .load_6_o(ld[2][6]), .load_7_o(ld[2][7]),
        .A_S_op_o(as_op[2]), .left_right_o(lr[2]), .bit_shift_o(bs[2]),
        .ctrl_a_o(ca[2]), .ctrl_b_o(cb[2]), .ctrl_c_o(cc[2]), .ctrl_d_o(cd[2]), .ctrl_e_o(ce[2]),
        .rst_int(rsti[2]), .busy_o(busy[2]), .ready_o(rdy[2]), .lat_cnt_o(lat2));

    // Instance configuration, mirrored from the parameter overrides above
    function automatic bit round_en(input int d);
        return d != 1;
    endfunction

    function automatic bit zero_byp(input int d);
        return d != 1;
    endfunction

    function automatic int lat_max(input int d);
        return (d == 2) ? 7 : 63;
    endfunction

    function automatic int get_lat(input int d);
        case (d)
            0:       return int'(lat0);
            1:       return int'(lat1);
            default: return int'(lat2);
        endcase
    endfunction

    // Busy cycles of one operation: LOAD_OPER + ZERO_CHK, then two passes of
    // exponent load / normalise with one add and one overflow check, the
    // optional round check and round add (one more exponent load if the round
    // add overflows), and finally the result load.
    function automatic int model_cycles(input int d, input bit z, input bit o, input bit r);
        int n;
        if (z && zero_byp(d)) return 2;
        n = 2 + 6 + 1;
        if (round_en(d)) begin
            n = n + 1;
            if (r) n = n + (o ? 3 : 2);
        end
        return n;
    endfunction

    function automatic int model_loads(input int d, input int k, input bit z, input bit o, input bit r);
        bit rr;
        rr = round_en(d) && r;
        if (k == 1) return 1;
        if (z && zero_byp(d)) return 0;
        case (k)
            2:       return 2;
            3:       return 2 + ((rr && o) ? 1 : 0);
            4:       return 2 + (rr ? 1 : 0);
            5:       return 1 + (round_en(d) ? 1 : 0);
            default: return 1;
        endcase
    endfunction

    function automatic int sat(input int d, input int v);
        return (v > lat_max(d)) ? lat_max(d) : v;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        start_i = 1'b0; ack_i = 1'b0; abort_i = 1'b0;
        zero_flag_i = 1'b0; add_overflow_i = 1'b0; round_i = 1'b0;
        #12;
        for (int d = 0; d < 3; d++) begin
            n_total++; if (ld[d] !== 7'b0) $display("[TB] FAIL reset_loads dut%0d: got %b expected 0", d, ld[d]); else n_pass++;
            n_total++; if (rsti[d] !== 1'b1) $display("[TB] FAIL reset_rst_int dut%0d: got %b expected 1", d, rsti[d]); else n_pass++;
            n_total++; if ({busy[d], rdy[d]} !== 2'b00) $display("[TB] FAIL reset_status dut%0d: got %b expected 00", d, {busy[d], rdy[d]}); else n_pass++;
            n_total++; if (as_op[d] !== 1'b1) $display("[TB] FAIL reset_A_S_op dut%0d: got %b expected 1", d, as_op[d]); else n_pass++;
            n_total++; if (get_lat(d) !== 0) $display("[TB] FAIL reset_lat dut%0d: got %0d expected 0", d, get_lat(d)); else n_pass++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            n_total++; if ({rsti[d], busy[d], rdy[d]} !== 3'b100) $display("[TB] FAIL post_reset_idle dut%0d: got %b expected 100", d, {rsti[d], busy[d], rdy[d]}); else n_pass++;
        end
    endtask

    // One complete operation with the flags held constant throughout
    task automatic test_operation(input bit z, input bit o, input bit r);
        int cnt [3][8];
        int ne3 [3];
        int rdy_cyc [3];
        int exp_cyc;
        bit all_rdy;
        zero_flag_i = z; add_overflow_i = o; round_i = r;
        ack_i = 1'b0; abort_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rdy_cyc[d] = -1;
            ne3[d] = 0;
            for (int k = 0; k < 8; k++) cnt[d][k] = 0;
        end
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            all_rdy = 1'b1;
            for (int d = 0; d < 3; d++) begin
                for (int k = 1; k <= 7; k++) if (ld[d][k]) cnt[d][k]++;
                if (cd[d]) cnt[d][0]++;
                if (ce[d] == 2'b11) ne3[d]++;
                if (rdy[d] && rdy_cyc[d] < 0) rdy_cyc[d] = c;
                if (rdy_cyc[d] < 0) all_rdy = 1'b0;
            end
            if (c == 1) begin
                n_total++; if (busy !== 3'b111) $display("[TB] FAIL busy_cycle1: got %b expected 111", busy); else n_pass++;
            end
            // Cycle 6 is the first-pass overflow check
            if (c == 6 && !z) begin
                n_total++;
                if (o ? ({as_op[0], cb[0], ce[0], lr[0], bs[0]} !== 7'b0_10_10_0_1)
                      : ({as_op[0], cb[0], ce[0], lr[0], bs[0]} !== 7'b1_01_01_1_0))
                    $display("[TB] FAIL ovf_chk_selects ovf=%0d: got %b", o, {as_op[0], cb[0], ce[0], lr[0], bs[0]});
                else n_pass++;
            end
            if (all_rdy) break;
            @(posedge clk); #1;
        end
        for (int d = 0; d < 3; d++) begin
            exp_cyc = model_cycles(d, z, o, r);
            n_total++; if (rdy_cyc[d] != exp_cyc + 1) $display("[TB] FAIL ready_cycle dut%0d z%0d o%0d r%0d: got %0d expected %0d", d, z, o, r, rdy_cyc[d], exp_cyc + 1); else n_pass++;
            n_total++; if (get_lat(d) != sat(d, exp_cyc)) $display("[TB] FAIL lat_cnt dut%0d z%0d o%0d r%0d: got %0d expected %0d", d, z, o, r, get_lat(d), sat(d, exp_cyc)); else n_pass++;
            for (int k = 1; k <= 7; k++) begin
                n_total++; if (cnt[d][k] != model_loads(d, k, z, o, r)) $display("[TB] FAIL load_%0d_count dut%0d z%0d o%0d r%0d: got %0d expected %0d", k, d, z, o, r, cnt[d][k], model_loads(d, k, z, o, r)); else n_pass++;
            end
            n_total++; if (cnt[d][0] != ((round_en(d) && r && !(z && zero_byp(d))) ? 1 : 0)) $display("[TB] FAIL ctrl_d_count dut%0d: got %0d", d, cnt[d][0]); else n_pass++;
            n_total++; if (ne3[d] != ((round_en(d) && r && !o && !(z && zero_byp(d))) ? 1 : 0)) $display("[TB] FAIL ctrl_e_round_count dut%0d: got %0d", d, ne3[d]); else n_pass++;
        end
        ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_total++; if ({rsti[d], busy[d], rdy[d]} !== 3'b100) $display("[TB] FAIL ack_to_idle dut%0d: got %b expected 100", d, {rsti[d], busy[d], rdy[d]}); else n_pass++;
            n_total++; if (get_lat(d) != sat(d, model_cycles(d, z, o, r))) $display("[TB] FAIL lat_hold_idle dut%0d: got %0d expected %0d", d, get_lat(d), sat(d, model_cycles(d, z, o, r))); else n_pass++;
        end
    endtask

    task automatic test_directed();
        test_operation(1'b0, 1'b0, 1'b0);
        test_operation(1'b0, 1'b0, 1'b1);
        test_operation(1'b0, 1'b1, 1'b1);
        test_operation(1'b0, 1'b1, 1'b0);
        test_operation(1'b1, 1'b0, 1'b0);
        test_operation(1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_operation(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        bit all_rdy;
        zero_flag_i = 1'b1; add_overflow_i = 1'b0; round_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        all_rdy = 1'b0;
        for (int c = 1; c <= 40 && !all_rdy; c++) begin
            @(posedge clk); #1;
            all_rdy = (rdy == 3'b111);
        end
        n_total++; if (rdy !== 3'b111) $display("[TB] FAIL b2b_reach_done: got %b expected 111", rdy); else n_pass++;
        // Start and abort without ack must be ignored while the result waits
        start_i = 1'b1; abort_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_total++; if (rdy !== 3'b111) $display("[TB] FAIL done_hold_ready cycle%0d: got %b expected 111", c, rdy); else n_pass++;
            n_total++; if ({ld[0][1], ld[1][1], ld[2][1], busy} !== 6'b0) $display("[TB] FAIL done_hold_no_start cycle%0d: got %b expected 0", c, {ld[0][1], ld[1][1], ld[2][1], busy}); else n_pass++;
        end
        abort_i = 1'b0; ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0; start_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_total++; if ({ld[d][1], busy[d], rdy[d]} !== 3'b110) $display("[TB] FAIL b2b_restart dut%0d: got %b expected 110", d, {ld[d][1], busy[d], rdy[d]}); else n_pass++;
            n_total++; if (get_lat(d) != 0) $display("[TB] FAIL b2b_lat_clear dut%0d: got %0d expected 0", d, get_lat(d)); else n_pass++;
        end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_total++; if ({rsti[d], busy[d], rdy[d]} !== 3'b100) $display("[TB] FAIL b2b_abort_idle dut%0d: got %b expected 100", d, {rsti[d], busy[d], rdy[d]}); else n_pass++;
        end
    endtask

    task automatic test_abort();
        int ready_seen;
        zero_flag_i = 1'b0; add_overflow_i = 1'b0; round_i = 1'b0;
        // Abort in IDLE is ignored, so the start is still taken
        start_i = 1'b1; abort_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0;
        n_total++; if (busy !== 3'b111) $display("[TB] FAIL abort_in_idle_ignored: got %b expected 111", busy); else n_pass++;
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk); #1;
        end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        ready_seen = 0;
        for (int d = 0; d < 3; d++) begin
            n_total++; if ({rsti[d], busy[d], rdy[d]} !== 3'b100) $display("[TB] FAIL abort_ovf_chk_idle dut%0d: got %b expected 100", d, {rsti[d], busy[d], rdy[d]}); else n_pass++;
        end
        for (int c = 0; c < 12; c++) begin
            if (rdy != 3'b000 || busy != 3'b000) ready_seen++;
            @(posedge clk); #1;
        end
        n_total++; if (ready_seen != 0) $display("[TB] FAIL abort_no_ready: got %0d active cycles expected 0", ready_seen); else n_pass++;
        for (int d = 0; d < 3; d++) begin
            n_total++; if (get_lat(d) != 5) $display("[TB] FAIL abort_lat_frozen dut%0d: got %0d expected 5", d, get_lat(d)); else n_pass++;
        end
        // Abort in the result-load cycle suppresses load_7 (dut1 is in DONE
        // by then and must ignore the abort)
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        abort_i = 1'b1;
        #1;
        n_total++; if ({ld[0][7], ld[2][7]} !== 2'b00) $display("[TB] FAIL abort_no_load7: got %b expected 00", {ld[0][7], ld[2][7]}); else n_pass++;
        @(posedge clk); #1;
        abort_i = 1'b0;
        n_total++; if ({busy[0], busy[2], rdy[0], rdy[2]} !== 4'b0) $display("[TB] FAIL abort_result_idle: got %b expected 0000", {busy[0], busy[2], rdy[0], rdy[2]}); else n_pass++;
        n_total++; if (rdy[1] !== 1'b1) $display("[TB] FAIL abort_in_done_ignored: got %b expected 1", rdy[1]); else n_pass++;
        n_total++; if (get_lat(0) != 9) $display("[TB] FAIL abort_late_lat: got %0d expected 9", get_lat(0)); else n_pass++;
        ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0;
    endtask

    task automatic test_async_reset();
        zero_flag_i = 1'b0; add_overflow_i = 1'b0; round_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk); #1;
        end
        n_total++; if (ld[0][4] !== 1'b1) $display("[TB] FAIL pre_reset_norm: got %b expected 1", ld[0][4]); else n_pass++;
        #1;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_total++; if (ld[d] !== 7'b0) $display("[TB] FAIL async_reset_loads dut%0d: got %b expected 0", d, ld[d]); else n_pass++;
            n_total++; if ({rsti[d], busy[d], rdy[d]} !== 3'b100) $display("[TB] FAIL async_reset_idle dut%0d: got %b expected 100", d, {rsti[d], busy[d], rdy[d]}); else n_pass++;
            n_total++; if (get_lat(d) != 0) $display("[TB] FAIL async_reset_lat dut%0d: got %0d expected 0", d, get_lat(d)); else n_pass++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            n_total++; if ({ld[d], busy[d], rsti[d]} !== 9'b0000000_0_1) $display("[TB] FAIL reset_release_idle dut%0d: got %b", d, {ld[d], busy[d], rsti[d]}); else n_pass++;
        end
        test_operation(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
